lsu_ctrl: RTL and testbench
===========================

# lsu_ctrl

Load/store controller for the CPU memory stage. It is the initiator side of the data-memory interface. It accepts one load or store per instruction (byte address from `aluout`, `store_data`, access size) and issues a request/grant/response transaction to the data memory. It steers and extends byte lanes, and stalls the pipeline until the access completes. Branch resolution (`pcsrc`) stays in the memory block and is not handled here.

## Interface
- `ADDR_W`, 32, byte-address width
- `MEM_DEPTH`, 32, data memory size in 32-bit words; higher addresses are rejected
- `TIMEOUT`, 15, max cycles waiting in REQ or RESP before abort

- `clk`  in  1  clock, all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `ex_valid`  in  1  memory-stage instruction valid
- `mem_read`  in  1  load
- `mem_write`  in  1  store
- `size`  in  2  00 byte, 01 half, 10 word, 11 illegal
- `is_unsigned`  in  1  zero-extend loads
- `aluout`  in  ADDR_W  byte address
- `store_data`  in  32  store value (right-justified)
- `stall`  out  1  hold pipeline
- `read_data`  out  32  formatted load result
- `load_valid`  out  1  one-cycle pulse, `read_data` valid
- `err`  out  1  one-cycle pulse: misaligned, illegal size, read&write both set, out of range, or timeout
- `dm_req`  out  1  request to data memory
- `dm_we`  out  1  write request
- `dm_addr`  out  ADDR_W  word-aligned byte address (`aluout` with [1:0] = 0)
- `dm_wdata`  out  32  lane-replicated store data
- `dm_be`  out  4  byte enables
- `dm_gnt`  in  1  request accepted this cycle
- `dm_rvalid`  in  1  read data valid
- `dm_rdata`  in  32  read data

## Operation
- **States:** IDLE, REQ, RESP, DONE.
- **IDLE, `ex_valid` with exactly one of `mem_read`/`mem_write`:**
  - Check alignment: half requires `aluout[0]=0`; word requires `aluout[1:0]=0`.
  - Check `size != 11` and `aluout < MEM_DEPTH*4`.
  - Any check fails: `err` pulses next cycle, no request, stay IDLE, `stall=0`.
  - Checks pass: latch op into `dm_*` registers and go to REQ.
- **IDLE, both `mem_read` and `mem_write` set:** `err` pulses, no request. Neither set: no action.
- **REQ:**
  - `dm_req=1`; `dm_addr`, `dm_we`, `dm_wdata`, `dm_be` stay stable until `dm_gnt`.
  - On `dm_gnt`: stores go to DONE, loads go to RESP.
  - `dm_rvalid` is ignored in REQ.
- **RESP:** `dm_req=0`. On `dm_rvalid`, register the formatted load into `read_data` and go to DONE. `dm_gnt` is ignored.
- **DONE:**
  - `load_valid=1` for loads only; go to IDLE.
  - `ex_valid` is ignored, because the completing instruction is still in the stage.
- **Byte enables:**
  - Byte: `dm_be = 1<<aluout[1:0]`.
  - Half: `dm_be = aluout[1] ? 1100 : 0011`.
  - Word: `dm_be = 1111`.
- **Store data:** byte `{4{sd[7:0]}}`, half `{2{sd[15:0]}}`, word `sd`.
- **Load data:** select the lane given by latched `aluout[1:0]`, then sign-extend, or zero-extend when `is_unsigned`.
- **Timeout:**
  - A counter clears on entry to REQ and to RESP, and increments each cycle there.
  - At `TIMEOUT`, go to IDLE and pulse `err`. `dm_req` drops, `load_valid` stays 0, `read_data` is unchanged.

## Timing
- **Reset values:** all outputs 0; state IDLE; counter 0.
- **Reset mid-operation:** reset in any state returns to IDLE at that edge and `dm_req` drops. A late `dm_rvalid` is ignored in IDLE.
- **`stall`:** combinational; `stall = (state==IDLE && accepting) || state==REQ || state==RESP || timeout_abort_pending`. `stall=0` in DONE.
- **Store latency:** with `dm_gnt` in the first REQ cycle, `stall` is high 2 cycles (accept, REQ) and DONE follows on the 3rd.
- **Load latency:** with immediate grant and `dm_rvalid` one cycle later, `stall` is high 3 cycles; `load_valid` and `read_data` appear in DONE on the 4th.
- **Back-to-back:** accesses need ≥1 IDLE cycle between them. The next op is accepted the cycle after DONE.
- **`err` pulse:** exactly one cycle, registered.

## Structure
- Shared package `lsu_pkg`:
  - `size_t` enum (BYTE, HALF, WORD)
  - `lsu_state_t` enum
  - functions `gen_be(size, addr_lo)` and `replicate_store(size, data)`
- Sub-module `lsu_align`: combinational lane select plus sign/zero extension (`dm_rdata`, `addr_lo`, `size`, `is_unsigned` → 32-bit result). Instantiated once.

## Test plan
- **sw word store:** `aluout=20`, `store_data=0xDEADBEEF`, `dm_gnt` immediate → `dm_addr=20`, `dm_be=1111`, `dm_wdata=0xDEADBEEF`, `dm_we=1`; `stall` high 2 cycles, no `load_valid`.
- **lb/lbu byte loads:** `aluout=21`, `dm_rdata=0xDEADBEEF`, `dm_be=0010`. Signed load → `read_data=0xFFFFFFBE`, `load_valid` one cycle. Unsigned load → `0x000000BE`.
- **lh half load:** `aluout=22`, same `dm_rdata` → `dm_be=1100`, `read_data=0xFFFFDEAD`.
- **Rejected ops, no `dm_req`, `stall=0`, one `err` pulse each:**
  - misaligned lh at `aluout=21`
  - `aluout=128` with `MEM_DEPTH=32`
  - read and write both set
- **Delayed grant:** `dm_gnt` after 3 cycles, spurious `dm_rvalid` during REQ → `dm_*` outputs stable while waiting, spurious `dm_rvalid` ignored, correct data taken from the later `dm_rvalid`.
- **Timeout and reset mid-operation:**
  - No `dm_gnt` for 15 cycles → `err` pulse, `dm_req` drops, `stall` releases.
  - `rst` during RESP → all outputs 0, a later `dm_rvalid` produces no `load_valid`.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and lane helpers for the load/store controller.
package lsu_pkg;

  typedef enum logic [1:0] {
    BYTE = 2'b00,
    HALF = 2'b01,
    WORD = 2'b10
  } size_t;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RESP,
    DONE
  } lsu_state_t;

  function automatic logic [3:0] gen_be(input logic [1:0] size, input logic [1:0] addr_lo);
    logic [3:0] be;
    case (size)
      BYTE:    be = 4'b0001 << addr_lo;
      HALF:    be = addr_lo[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] replicate_store(input logic [1:0] size, input logic [31:0] data);
    logic [31:0] rep;
    case (size)
      BYTE:    rep = {4{data[7:0]}};
      HALF:    rep = {2{data[15:0]}};
      default: rep = data;
    endcase
    return rep;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Load formatter: picks the addressed lane and sign- or zero-extends it.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [31:0] dm_rdata,
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  output logic [31:0] result
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    lane_b = 8'(dm_rdata >> {addr_lo, 3'b000});
    lane_h = addr_lo[1] ? dm_rdata[31:16] : dm_rdata[15:0];
    case (size)
      BYTE:    result = {{24{lane_b[7] & ~is_unsigned}}, lane_b};
      HALF:    result = {{16{lane_h[15] & ~is_unsigned}}, lane_h};
      default: result = dm_rdata;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Memory-stage load/store controller: validates the access, runs a
// req/gnt/rvalid transaction to data memory and stalls until it completes.
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned MEM_DEPTH = 32,
  parameter int unsigned TIMEOUT   = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [1:0]        size,
  input  logic              is_unsigned,
  input  logic [ADDR_W-1:0] aluout,
  input  logic [31:0]       store_data,
  output logic              stall,
  output logic [31:0]       read_data,
  output logic              load_valid,
  output logic              err,
  output logic              dm_req,
  output logic              dm_we,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [31:0]       dm_wdata,
  output logic [3:0]        dm_be,
  input  logic              dm_gnt,
  input  logic              dm_rvalid,
  input  logic [31:0]       dm_rdata
);

  localparam int unsigned       CNT_W      = $clog2(TIMEOUT + 1);
  localparam logic [ADDR_W-1:0] ADDR_LIMIT = ADDR_W'(MEM_DEPTH * 4);

  lsu_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       op_lo;
  logic [1:0]       op_size;
  logic             op_unsigned;
  logic             op_load;
  logic [31:0]      load_fmt;

  logic one_op, both_op, align_ok, checks_ok, accept, reject, abort;

  // Request decode and legality checks, evaluated only in IDLE
  always_comb begin
    one_op  = mem_read ^ mem_write;
    both_op = mem_read & mem_write;
    case (size)
      HALF:    align_ok = ~aluout[0];
      WORD:    align_ok = (aluout[1:0] == 2'b00);
      default: align_ok = 1'b1;
    endcase
    checks_ok = align_ok && (size != 2'b11) && (aluout < ADDR_LIMIT);
    accept    = (state == IDLE) && ex_valid && one_op && checks_ok;
    reject    = (state == IDLE) && ex_valid && (both_op || (one_op && !checks_ok));
    abort     = (cnt == CNT_W'(TIMEOUT - 1)) &&
                (((state == REQ) && !dm_gnt) || ((state == RESP) && !dm_rvalid));
  end

  assign stall = accept || (state == REQ) || (state == RESP) || abort;

  lsu_align u_align (
    .dm_rdata    (dm_rdata),
    .addr_lo     (op_lo),
    .size        (op_size),
    .is_unsigned (op_unsigned),
    .result      (load_fmt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      read_data   <= '0;
      load_valid  <= 1'b0;
      err         <= 1'b0;
      dm_req      <= 1'b0;
      dm_we       <= 1'b0;
      dm_addr     <= '0;
      dm_wdata    <= '0;
      dm_be       <= '0;
      op_lo       <= '0;
      op_size     <= '0;
      op_unsigned <= 1'b0;
      op_load     <= 1'b0;
    end else begin
      err        <= 1'b0;
      load_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            dm_req      <= 1'b1;
            dm_we       <= mem_write;
            dm_addr     <= {aluout[ADDR_W-1:2], 2'b00};
            dm_wdata    <= replicate_store(size, store_data);
            dm_be       <= gen_be(size, aluout[1:0]);
            op_lo       <= aluout[1:0];
            op_size     <= size;
            op_unsigned <= is_unsigned;
            op_load     <= mem_read;
            cnt         <= '0;
            state       <= REQ;
          end else if (reject) begin
            err <= 1'b1;
          end
        end
        REQ: begin
          if (dm_gnt) begin
            dm_req <= 1'b0;
            cnt    <= '0;
            state  <= op_load ? RESP : DONE;
          end else if (abort) begin
            dm_req <= 1'b0;
            err    <= 1'b1;
            state  <= IDLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        RESP: begin
          if (dm_rvalid) begin
            read_data  <= load_fmt;
            load_valid <= 1'b1;
            state      <= DONE;
          end else if (abort) begin
            err   <= 1'b1;
            state <= IDLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Scenario bench for lsu_ctrl with a load-result scoreboard queue.
module tb_lsu_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid, mem_read, mem_write, is_unsigned;
  logic [1:0]  size;
  logic [31:0] aluout, store_data;
  logic        stall, load_valid, err, dm_req, dm_we;
  logic [31:0] read_data, dm_addr, dm_wdata, dm_rdata;
  logic [3:0]  dm_be;
  logic        dm_gnt, dm_rvalid;

  int          vec  = 0;
  int          miss = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  lsu_ctrl #(.ADDR_W(32), .MEM_DEPTH(32), .TIMEOUT(15)) dut (
    .clk         (clk),
    .rst         (rst),
    .ex_valid    (ex_valid),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .size        (size),
    .is_unsigned (is_unsigned),
    .aluout      (aluout),
    .store_data  (store_data),
    .stall       (stall),
    .read_data   (read_data),
    .load_valid  (load_valid),
    .err         (err),
    .dm_req      (dm_req),
    .dm_we       (dm_we),
    .dm_addr     (dm_addr),
    .dm_wdata    (dm_wdata),
    .dm_be       (dm_be),
    .dm_gnt      (dm_gnt),
    .dm_rvalid   (dm_rvalid),
    .dm_rdata    (dm_rdata)
  );

  task automatic drive_op(input logic rd, input logic wr, input logic [1:0] sz,
                          input logic uns, input logic [31:0] addr, input logic [31:0] sd);
    ex_valid    = 1'b1;
    mem_read    = rd;
    mem_write   = wr;
    size        = sz;
    is_unsigned = uns;
    aluout      = addr;
    store_data  = sd;
  endtask

  task automatic clear_op();
    ex_valid  = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_op();
    size = 2'b00; is_unsigned = 1'b0; aluout = '0; store_data = '0;
    dm_gnt = 1'b0; dm_rvalid = 1'b0; dm_rdata = '0;
    repeat (2) @(negedge clk);
    vec++;
    if ({stall, load_valid, err, dm_req, dm_we, dm_be} !== 9'd0) begin
      miss++; $display("FAIL reset_ctrl: got %b exp 0", {stall, load_valid, err, dm_req, dm_we, dm_be});
    end
    vec++;
    if ({dm_addr, dm_wdata, read_data} !== 96'd0) begin
      miss++; $display("FAIL reset_data: got %h exp 0", {dm_addr, dm_wdata, read_data});
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_store(input logic [1:0] sz, input logic [31:0] addr, input logic [31:0] sd,
                            input logic [31:0] exp_wdata, input logic [3:0] exp_be);
    drive_op(1'b0, 1'b1, sz, 1'b0, addr, sd);
    #1;
    vec++;
    if (stall !== 1'b1) begin miss++; $display("FAIL st_accept_stall @%0d: got %b exp 1", addr, stall); end
    @(negedge clk);
    vec++;
    if ({dm_req, dm_we, dm_addr, dm_be, dm_wdata, stall} !== {1'b1, 1'b1, addr & ~32'd3, exp_be, exp_wdata, 1'b1}) begin
      miss++;
      $display("FAIL st_req @%0d: got req=%b we=%b addr=%h be=%b wd=%h stall=%b exp addr=%h be=%b wd=%h",
               addr, dm_req, dm_we, dm_addr, dm_be, dm_wdata, stall, addr & ~32'd3, exp_be, exp_wdata);
    end
    clear_op();
    dm_gnt = 1'b1;
    @(negedge clk);
    dm_gnt = 1'b0;
    vec++;
    if ({stall, dm_req, load_valid, err} !== 4'b0000) begin
      miss++; $display("FAIL st_done @%0d: got stall/req/lv/err=%b exp 0000", addr, {stall, dm_req, load_valid, err});
    end
    @(negedge clk);
    vec++;
    if ({load_valid, err} !== 2'b00) begin
      miss++; $display("FAIL st_idle @%0d: got lv/err=%b exp 00", addr, {load_valid, err});
    end
  endtask

  task automatic test_load(input logic [1:0] sz, input logic uns, input logic [31:0] addr,
                           input logic [31:0] rdata, input logic [3:0] exp_be, input logic [31:0] exp_rd,
                           input int gnt_delay, input logic spurious);
    logic [31:0] want;
    exp_q.push_back(exp_rd);
    drive_op(1'b1, 1'b0, sz, uns, addr, 32'h0);
    #1;
    vec++;
    if (stall !== 1'b1) begin miss++; $display("FAIL ld_accept_stall @%0d: got %b exp 1", addr, stall); end
    for (int k = 0; k <= gnt_delay; k++) begin
      @(negedge clk);
      clear_op();
      vec++;
      if ({dm_req, dm_we, dm_addr, dm_be, stall} !== {1'b1, 1'b0, addr & ~32'd3, exp_be, 1'b1}) begin
        miss++;
        $display("FAIL ld_req @%0d cyc%0d: got req=%b we=%b addr=%h be=%b stall=%b exp addr=%h be=%b",
                 addr, k, dm_req, dm_we, dm_addr, dm_be, stall, addr & ~32'd3, exp_be);
      end
      dm_gnt    = (k == gnt_delay);
      dm_rvalid = spurious && (k < gnt_delay);
      dm_rdata  = dm_rvalid ? 32'h1111_1111 : 32'h0;
    end
    @(negedge clk);
    dm_gnt = 1'b0;
    vec++;
    if ({dm_req, stall, load_valid} !== 3'b010) begin
      miss++; $display("FAIL ld_resp @%0d: got req/stall/lv=%b exp 010", addr, {dm_req, stall, load_valid});
    end
    dm_rvalid = 1'b1;
    dm_rdata  = rdata;
    @(negedge clk);
    dm_rvalid = 1'b0;
    dm_rdata  = 32'h0;
    vec++;
    if ({load_valid, stall} !== 2'b10) begin
      miss++; $display("FAIL ld_done @%0d: got lv/stall=%b exp 10", addr, {load_valid, stall});
    end
    want = exp_q.pop_front();
    vec++;
    if (read_data !== want) begin
      miss++; $display("FAIL ld_data @%0d: got %h exp %h", addr, read_data, want);
    end
    @(negedge clk);
    vec++;
    if (load_valid !== 1'b0) begin miss++; $display("FAIL ld_pulse @%0d: got %b exp 0", addr, load_valid); end
  endtask

  task automatic test_reject(input string name, input logic rd, input logic wr,
                             input logic [1:0] sz, input logic [31:0] addr);
    drive_op(rd, wr, sz, 1'b0, addr, 32'h5555_5555);
    #1;
    vec++;
    if (stall !== 1'b0) begin miss++; $display("FAIL %s_stall: got %b exp 0", name, stall); end
    @(negedge clk);
    vec++;
    if ({err, dm_req, stall} !== 3'b100) begin
      miss++; $display("FAIL %s_err: got err/req/stall=%b exp 100", name, {err, dm_req, stall});
    end
    clear_op();
    @(negedge clk);
    vec++;
    if ({err, dm_req} !== 2'b00) begin
      miss++; $display("FAIL %s_clear: got err/req=%b exp 00", name, {err, dm_req});
    end
  endtask

  task automatic test_back_to_back();
    test_store(2'b10, 32'd8, 32'h0BAD_F00D, 32'h0BAD_F00D, 4'b1111);
    test_load(2'b10, 1'b0, 32'd8, 32'h0BAD_F00D, 4'b1111, 32'h0BAD_F00D, 0, 1'b0);
  endtask

  task automatic test_timeout();
    int n;
    drive_op(1'b0, 1'b1, 2'b10, 1'b0, 32'd40, 32'h1234_5678);
    @(negedge clk);
    clear_op();
    n = 0;
    while (dm_req === 1'b1 && n < 40) begin
      n++;
      @(negedge clk);
    end
    vec++;
    if (n !== 15) begin miss++; $display("FAIL to_cycles: got %0d exp 15", n); end
    vec++;
    if ({err, dm_req, stall} !== 3'b100) begin
      miss++; $display("FAIL to_abort: got err/req/stall=%b exp 100", {err, dm_req, stall});
    end
    @(negedge clk);
    vec++;
    if ({err, load_valid} !== 2'b00) begin
      miss++; $display("FAIL to_pulse: got err/lv=%b exp 00", {err, load_valid});
    end
  endtask

  task automatic test_reset_mid();
    drive_op(1'b1, 1'b0, 2'b10, 1'b0, 32'd4, 32'h0);
    @(negedge clk);
    clear_op();
    dm_gnt = 1'b1;
    @(negedge clk);
    dm_gnt = 1'b0;
    vec++;
    if ({dm_req, stall} !== 2'b01) begin
      miss++; $display("FAIL rm_resp: got req/stall=%b exp 01", {dm_req, stall});
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    vec++;
    if ({stall, load_valid, err, dm_req, dm_we, dm_be, dm_addr, dm_wdata, read_data} !== 105'd0) begin
      miss++;
      $display("FAIL rm_reset: got stall=%b lv=%b err=%b req=%b we=%b be=%b addr=%h wd=%h rd=%h exp all 0",
               stall, load_valid, err, dm_req, dm_we, dm_be, dm_addr, dm_wdata, read_data);
    end
    dm_rvalid = 1'b1;
    dm_rdata  = 32'hA5A5_A5A5;
    @(negedge clk);
    dm_rvalid = 1'b0;
    vec++;
    if ({load_valid, stall, read_data} !== 34'd0) begin
      miss++; $display("FAIL rm_late_rvalid: got lv=%b stall=%b rd=%h exp 0", load_valid, stall, read_data);
    end
    @(negedge clk);
    vec++;
    if (load_valid !== 1'b0) begin miss++; $display("FAIL rm_late_lv: got %b exp 0", load_valid); end
  endtask

  initial begin
    test_reset();
    test_store(2'b10, 32'd20, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 4'b1111);
    test_store(2'b00, 32'd23, 32'h0000_00A5, 32'hA5A5_A5A5, 4'b1000);
    test_store(2'b01, 32'd22, 32'h1234_BEEF, 32'hBEEF_BEEF, 4'b1100);
    test_load(2'b00, 1'b0, 32'd21, 32'hDEAD_BEEF, 4'b0010, 32'hFFFF_FFBE, 0, 1'b0);
    test_load(2'b00, 1'b1, 32'd21, 32'hDEAD_BEEF, 4'b0010, 32'h0000_00BE, 0, 1'b0);
    test_load(2'b01, 1'b0, 32'd22, 32'hDEAD_BEEF, 4'b1100, 32'hFFFF_DEAD, 0, 1'b0);
    test_load(2'b00, 1'b0, 32'd23, 32'h7F00_0000, 4'b1000, 32'h0000_007F, 0, 1'b0);
    test_load(2'b01, 1'b1, 32'd0,  32'h0000_8001, 4'b0011, 32'h0000_8001, 0, 1'b0);
    test_reject("misaligned_lh", 1'b1, 1'b0, 2'b01, 32'd21);
    test_reject("out_of_range",  1'b1, 1'b0, 2'b10, 32'd128);
    test_reject("rd_and_wr",     1'b1, 1'b1, 2'b10, 32'd0);
    test_reject("illegal_size",  1'b0, 1'b1, 2'b11, 32'd0);
    test_load(2'b10, 1'b0, 32'd24, 32'hCAFE_F00D, 4'b1111, 32'hCAFE_F00D, 3, 1'b1);
    test_back_to_back();
    test_timeout();
    test_reset_mid();
    vec++;
    if (exp_q.size() !== 0) begin miss++; $display("FAIL scoreboard_left: got %0d exp 0", exp_q.size()); end
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
